instr_fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle core's decode/controller. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake that tolerates variable latency. It buffers returned words with their PCs in a small prefetch FIFO and presents them to the core through a valid/ready handshake. Branch/jump redirects from the core flush the buffer and restart fetch at the target.

---
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage in front of the core's decode/controller. Owns the
// fetch PC, issues one word request at a time to instruction memory over a
// req/ack handshake, buffers returned words with their PCs in a small prefetch
// FIFO, and hands them to the core over a valid/ready handshake. A redirect
// from the core flushes the FIFO and restarts fetch at the target.
//
// Handshakes:
//   Memory side : mem_req/mem_addr are held stable from the cycle mem_req
//                 rises until the cycle mem_ack=1 (ack may arrive in the first
//                 req cycle). mem_ack while mem_req=0 is ignored.
//   Core side   : the head transfers when instr_valid && instr_ready in the
//                 same cycle; instr_ready with an empty FIFO has no effect.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   mem_req      instruction-memory request
//   mem_addr     word address of the request (bits[1:0]=00)
//   mem_rdata    instruction word, valid with mem_ack
//   mem_ack      memory completes the current request this cycle
//   instr_out    instruction at FIFO head (0 when empty)
//   pc_out       PC of instr_out (0 when empty)
//   pc_plus4     pc_out + 4
//   instr_valid  FIFO head is valid
//   instr_ready  core consumes head this cycle
//   redirect     one-cycle pulse: taken branch/jump
//   redirect_pc  redirect target (bits[1:0] forced to 00)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(BUF_DEPTH);
   localparam logic [31:0]      RESET_PC_A = {RESET_PC[31:2], 2'b00};

   // IDLE    : no request, waiting for FIFO space
   // BUSY    : request to fetch_pc outstanding
   // DISCARD : request to a pre-redirect address outstanding; its data is dropped
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_DISCARD = 2'd2
   } state_e;

   state_e             state_q,    state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic               mem_req_q,  mem_req_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;

   logic [31:0]        instr_buf [BUF_DEPTH];
   logic [31:0]        pc_buf    [BUF_DEPTH];

   logic               head_valid;
   logic               pop;
   logic               push;
   logic [CNT_W-1:0]   count_after_pop;
   logic [CNT_W-1:0]   count_after;
   logic [31:0]        target_pc;
   logic               unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign target_pc            = {redirect_pc[31:2], 2'b00};

   assign head_valid      = (count_q != '0);
   // A redirect voids both the pop and the push of its cycle.
   assign pop             = head_valid && instr_ready && !redirect;
   assign push            = (state_q == S_BUSY) && mem_ack && !redirect;
   assign count_after_pop = count_q - CNT_W'(pop);
   assign count_after     = count_after_pop + CNT_W'(push);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (redirect) begin
         fetch_pc_d = target_pc;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_after;
      end

      // A request is only started when a FIFO slot is free for its data,
      // so a push can never overflow.
      case (state_q)
         S_IDLE: begin
            if (redirect || (count_after_pop < DEPTH_C)) state_d = S_BUSY;
         end
         S_BUSY: begin
            if (redirect) begin
               state_d = mem_ack ? S_BUSY : S_DISCARD;
            end else if (mem_ack) begin
               state_d = (count_after < DEPTH_C) ? S_BUSY : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (mem_ack) state_d = S_BUSY;
         end
         default: state_d = S_IDLE;
      endcase

      // In BUSY mem_addr tracks fetch_pc; in DISCARD it keeps the stale
      // address even though fetch_pc has already moved to the target.
      mem_req_d  = (state_d != S_IDLE);
      mem_addr_d = (state_d == S_DISCARD) ? mem_addr_q : fetch_pc_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC_A;
         mem_addr_q <= RESET_PC_A;
         mem_req_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage is not reset; the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_buf[wr_ptr_q] <= mem_rdata;
         pc_buf[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr_valid = head_valid;
   assign instr_out   = head_valid ? instr_buf[rd_ptr_q] : 32'd0;
   assign pc_out      = head_valid ? pc_buf[rd_ptr_q]    : 32'd0;
   assign pc_plus4    = pc_out + 32'd4;

endmodule
